// File: rtl/fib_chk_pkg.sv
// Shared types, seeds and address-window helper for the Fibonacci table write checker.
package fib_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] SEED0 = 32'd1;
  localparam logic [31:0] SEED1 = 32'd1;

  // Widened arithmetic so a window ending at the top of the address space cannot wrap.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] count);
    logic [33:0] lim;
    lim = {2'b00, base} + {count, 2'b00};
    return ({2'b00, addr} >= {2'b00, base}) && ({2'b00, addr} < lim);
  endfunction

endpackage

// File: rtl/fib_seq_gen.sv
// Expected-value generator: walks the Fibonacci chain one step per advance strobe.
module fib_seq_gen
  import fib_chk_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        adv,
  output logic [31:0] exp_val
);

  logic [31:0] f1_r;
  logic [31:0] f2_r;
  logic [1:0]  step_r;

  // The first two indices return the seeds; afterwards the sum of the previous two.
  always_comb begin
    exp_val = f1_r + f2_r;
    case (step_r)
      2'd0:    exp_val = SEED0;
      2'd1:    exp_val = SEED1;
      default: exp_val = f1_r + f2_r;
    endcase
  end

  // Chain advances on the expected value, never on observed data, so errors do not cascade.
  always_ff @(posedge clk) begin
    if (clr) begin
      f1_r   <= SEED1;
      f2_r   <= SEED0;
      step_r <= 2'd0;
    end else if (adv) begin
      f2_r   <= f1_r;
      f1_r   <= exp_val;
      step_r <= (step_r == 2'd2) ? 2'd2 : step_r + 2'd1;
    end
  end

endmodule

// File: rtl/fib_write_checker.sv
// Passive monitor on the data-memory write port that verifies the Fibonacci table fill.
module fib_write_checker
  import fib_chk_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int unsigned WORD_COUNT = 1024,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_addr,
  input  logic [31:0]                   wr_data,
  input  logic [3:0]                    wr_strb,
  output logic                          done,
  output logic                          pass,
  output logic [ERR_WIDTH-1:0]          err_count,
  output logic                          first_err_valid,
  output logic [$clog2(WORD_COUNT)-1:0] first_err_index
);

  localparam int unsigned           IDX_W    = $clog2(WORD_COUNT);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(WORD_COUNT - 1);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX  = '1;
  localparam logic [ERR_WIDTH-1:0]  ERR_ONE  = {{(ERR_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_r;
  state_e               state_nxt_s;
  logic [IDX_W-1:0]     exp_idx_r;
  logic [IDX_W-1:0]     idx_s;
  logic [31:0]          exp_val_s;
  logic                 win_s;
  logic                 active_s;
  logic                 fmt_err_s;
  logic                 ord_err_s;
  logic                 dat_err_s;
  logic                 err_s;
  logic                 adv_s;
  logic                 last_s;
  logic [ERR_WIDTH-1:0] err_cnt_nxt_s;

  fib_seq_gen u_seq (
    .clk     (clk),
    .clr     (rst),
    .adv     (adv_s),
    .exp_val (exp_val_s)
  );

  // Decode of the sampled write against the priority-ordered error rules.
  always_comb begin
    win_s         = wr_en && addr_in_window(wr_addr, BASE_ADDR, 32'(WORD_COUNT));
    active_s      = win_s && (state_r != DONE);
    idx_s         = IDX_W'((wr_addr - BASE_ADDR) >> 2);
    fmt_err_s     = (wr_addr[1:0] != 2'b00) || (wr_strb != 4'b1111);
    ord_err_s     = (idx_s != exp_idx_r);
    dat_err_s     = (wr_data != exp_val_s);
    adv_s         = active_s && !fmt_err_s && !ord_err_s;
    err_s         = active_s && (fmt_err_s || ord_err_s || dat_err_s);
    last_s        = adv_s && (exp_idx_r == LAST_IDX);
    err_cnt_nxt_s = (err_s && (err_count != ERR_MAX)) ? err_count + ERR_ONE : err_count;
  end

  // Next-state logic; any in-window write leaves IDLE even if it is itself an error.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = win_s ? RUN : IDLE;
      RUN:     state_nxt_s = last_s ? DONE : RUN;
      DONE:    state_nxt_s = DONE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, index tracking and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      exp_idx_r       <= '0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_index <= '0;
    end else begin
      state_r   <= state_nxt_s;
      err_count <= err_cnt_nxt_s;
      if (adv_s) begin
        exp_idx_r <= exp_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
      end
      if (last_s) begin
        done <= 1'b1;
        pass <= (err_cnt_nxt_s == '0);
      end
      if (err_s && !first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_index <= exp_idx_r;
      end
    end
  end

endmodule

// File: doc/fib_write_checker.md
# fib_write_checker

Passive monitor on the core's data-memory write port that checks, on chip, the Fibonacci table written by the fill program: word 0 = 1, word 1 = 1, word i = word(i-1) + word(i-2) mod 2^32, at word addresses BASE_ADDR onward. It sits directly downstream of the core, beside data memory, inside the toplevel. It reports done/pass and error diagnostics for LEDs or a debug port.

## Interface
- BASE_ADDR, 32'h0000_1000: byte address of table word 0.
- WORD_COUNT, 1024: number of table words; power of two, at least 4.
- ERR_WIDTH, 16: width of the error counter.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  data-memory write strobe; one write per cycle when high.
- wr_addr  in  32  byte address of the write.
- wr_data  in  32  write data.
- wr_strb  in  4  byte enables.
- done  out  1  table fully observed; sticky until reset.
- pass  out  1  done and err_count == 0.
- err_count  out  ERR_WIDTH  saturating count of erroneous table writes.
- first_err_valid  out  1  first_err_index is meaningful.
- first_err_index  out  log2(WORD_COUNT)  index expected when the first error occurred.

## Operation
- Window: BASE_ADDR <= wr_addr < BASE_ADDR + 4*WORD_COUNT. Writes outside the window are ignored in every state.
- Index = (wr_addr - BASE_ADDR) >> 2. The expected index is exp_idx, starting at 0.
- FSM states:
  - IDLE: reset state. The first in-window write moves to RUN, whether or not it is an error.
  - RUN: checking writes.
  - DONE: entered when exp_idx advances past WORD_COUNT-1. Terminal until rst; no further checking; all outputs frozen.
- Rules for each in-window write in IDLE or RUN, checked in priority order:
  - wr_addr[1:0] != 0, or wr_strb != 4'b1111: error. exp_idx does not advance.
  - Index != exp_idx: order error. exp_idx does not advance.
  - Otherwise: compare wr_data with the expected value. A mismatch is an error. exp_idx advances either way.
- Expected-value chain: expected value = 1 for indices 0 and 1, else f1 + f2 (32-bit wrap, carry discarded).
- On each advance: f2 <= f1; f1 <= expected value, never the observed data. A single bad write therefore does not cascade into later errors.
- Error bookkeeping:
  - err_count increments by 1 per erroneous write and saturates at all-ones.
  - first_err_index and first_err_valid are captured on the first error only.
- Rewriting an already-checked index counts as an order error.

## Timing
- All outputs are registered. Reset values: done=0, pass=0, err_count=0, first_err_valid=0, first_err_index=0.
- Internal reset values: exp_idx=0, f1=f2=1.
- Write sampled at edge N affects outputs visible after edge N. The last table write raises done and pass on that same edge.
- Throughput: one write per cycle, back-to-back, with no stalls. There is no backpressure; the block never drives the core.
- rst mid-table: everything returns to reset values on the next edge, and the write sampled with rst high is ignored.
- Any wr_en=0 gap length between writes is allowed.

## Structure
- Shared package fib_chk_pkg:
  - state enum (IDLE, RUN, DONE);
  - constants SEED0=1, SEED1=1;
  - function addr_in_window(addr, base, count).
- One sub-module, fib_seq_gen: holds f1/f2, takes an advance strobe and a synchronous clear, outputs the expected value for the current index. The top module owns the FSM, decode, and error logic.

## Test plan
- Golden run: 1024 consecutive correct writes from 0x1000, one per cycle → done=1 and pass=1 on the cycle after write 1023; err_count=0.
- Wrap check: index 46 = 0xB11924E1 and index 47 = 0x1E8D0A40 (wrapped) both accepted → err_count stays 0.
- Bad data: index 10 written as 90 instead of 89, all else correct → final err_count=1, first_err_index=10, index 11 (144) is not flagged, pass=0 with done=1.
- Order/strobe errors: write index 3 before index 2 → err=1, exp_idx stays 2. Then a correct index-2 write with wr_strb=4'b0011 → err=2. Then the full write → accepted.
- Outside window and saturation: writes at 0x0FFC and 0x2000 → no effect. With ERR_WIDTH=2, 5 bad writes → err_count=3.
- Reset mid-run: rst high for 1 cycle after index 500 → all outputs 0. A fresh 1024-word golden run then → pass=1.
